// File: rtl/ci_pkg.sv
// ----------------------------------------------------------------------------
// ci_pkg
// Shared types and constants for the Nios II multi-cycle custom-instruction
// initiator.
//   ci_state_e : initiator FSM states
//   CI_DATA_W  : default operand/result width
// ----------------------------------------------------------------------------
package ci_pkg;

    localparam int CI_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ABORT,
        RESP
    } ci_state_e;

endpackage

// File: rtl/ci_timeout_ctr.sv
// ----------------------------------------------------------------------------
// ci_timeout_ctr
// Cycle counter that watches an outstanding custom instruction.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : synchronous clear (held while the instruction is issued)
//   enable       : count this cycle (WAIT and not halted)
//   expired      : this is the TIMEOUT_CYC-th enabled cycle since clear
// ----------------------------------------------------------------------------
module ci_timeout_ctr
    import ci_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CW'(TIMEOUT_CYC))) begin
            count <= count + CW'(1);
        end
    end

    // count is 0 on the first enabled cycle, so TIMEOUT_CYC-1 marks the
    // last cycle in which a done may still arrive before the abort.
    assign expired = enable && (count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/ci_initiator.sv
// ----------------------------------------------------------------------------
// ci_initiator
// Initiator for the Nios II multi-cycle custom-instruction interface.
// Accepts one operand pair on a valid/ready input, issues it to a CI slave
// (start/dataa/datab), waits for done, and returns the captured result on a
// valid/ready output. Only one instruction is ever in flight.
//
// Optional feature macro: CI_TIMEOUT_EN
//   defined   : WAIT aborts after TIMEOUT_CYC cycles without done; a one-cycle
//               ci_reset pulse is sent and the response carries out_err=1,
//               out_result=0.
//   undefined : WAIT holds indefinitely; out_err and ci_reset are tied low.
//
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   in_valid/in_ready       : operand handshake, operands on in_a/in_b
//   out_valid/out_ready     : result handshake, out_result/out_err
//   halt                    : freeze request, drives ci_clk_en low
//   busy                    : high in any state except IDLE
//   ci_clk_en, ci_reset,
//   ci_start, ci_dataa,
//   ci_datab                : custom-instruction master side
//   ci_done, ci_result      : custom-instruction slave response
// ----------------------------------------------------------------------------
module ci_initiator
    import ci_pkg::*;
#(
    parameter int DATA_W      = CI_DATA_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_err,
    input  logic              halt,
    output logic              busy,
    output logic              ci_clk_en,
    output logic              ci_reset,
    output logic              ci_start,
    output logic [DATA_W-1:0] ci_dataa,
    output logic [DATA_W-1:0] ci_datab,
    input  logic              ci_done,
    input  logic [DATA_W-1:0] ci_result
);

    ci_state_e state;
    ci_state_e state_nx;

    // Low during reset and for the first edge after release, so in_ready
    // only rises one cycle after reset_n goes high.
    logic started;
    logic accept;
    logic timeout_hit;

    assign ci_clk_en = ~halt;
    assign accept    = in_valid && in_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            started <= 1'b0;
        end else begin
            state   <= state_nx;
            started <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; halt freezes the FSM in place
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        if (!halt) begin
            case (state)
                IDLE:    if (accept) state_nx = ISSUE;
                ISSUE:   state_nx = WAIT;
                WAIT: begin
                    // done has priority over a simultaneous timeout
                    if (ci_done)          state_nx = RESP;
                    else if (timeout_hit) state_nx = ABORT;
                end
                ABORT:   state_nx = RESP;
                RESP:    if (out_ready) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        // gated by halt so a frozen initiator never completes a handshake
        in_ready  = (state == IDLE) && started && !halt;
        busy      = (state != IDLE);
        out_valid = (state == RESP);
        // stays high through halted cycles until the slave sees clk_en=1
        ci_start  = (state == ISSUE);
    end

    // ------------------------------------------------------------------
    // Operand and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ci_dataa   <= '0;
            ci_datab   <= '0;
            out_result <= '0;
        end else if (!halt) begin
            if ((state == IDLE) && accept) begin
                ci_dataa <= in_a;
                ci_datab <= in_b;
            end
            if ((state == WAIT) && ci_done) begin
                out_result <= ci_result;
            end
`ifdef CI_TIMEOUT_EN
            if (state == ABORT) begin
                out_result <= '0;
            end
`endif
        end
    end

`ifdef CI_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Timeout support
    // ------------------------------------------------------------------
    ci_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state == ISSUE),
        .enable  ((state == WAIT) && !halt),
        .expired (timeout_hit)
    );

    assign ci_reset = (state == ABORT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_err <= 1'b0;
        end else if (!halt) begin
            if ((state == WAIT) && ci_done) begin
                out_err <= 1'b0;
            end else if (state == ABORT) begin
                out_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign ci_reset    = 1'b0;
    assign out_err     = 1'b0;

    // TIMEOUT_CYC is only meaningful with the timeout feature built in.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

endmodule
